uart_rx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_fifo_sync_fifo.sv | 67 ++++++
 rtl/uart_rx_fifo.sv | 86 ++++++++
 tb/tb_uart_rx_fifo.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART receive-path constants: line-status bit positions and the FIFO entry layout.
package uart_pkg;

  localparam int LSR_DONE = 0;
  localparam int LSR_OVR  = 1;
  localparam int LSR_PERR = 2;
  localparam int LSR_FERR = 3;

  localparam int RXF_W = 10;

  // Entry as stored in the receive FIFO, MSB first.
  typedef struct packed {
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Generic single-clock circular FIFO with show-ahead read and a separate occupancy counter.
module sync_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic [AW:0]   count_o,
  output logic [AW:0]   count_nxt_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          room_o
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));

  // A pop in the same cycle frees a slot, so a full FIFO still accepts a push.
  assign do_pop  = pop_i & ~empty_o;
  assign room_o  = ~full_o | do_pop;
  assign do_push = push_i & room_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o     = mem[rd_ptr_q];
  assign count_o     = count_q;
  assign count_nxt_o = count_d;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures completed characters from the receiver, acknowledges them,
// tracks dropped characters and raises a fill-level interrupt for the host.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int THRESH = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic [7:0]    rx_lsr,
  output logic          clear_flags,
  output logic          fifo_full,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          rd_perr,
  output logic          rd_ferr,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overrun,
  input  logic          overrun_clr,
  output logic          rx_irq
);

  logic        clear_flags_q, clear_flags_d;
  logic        overrun_q, overrun_d;
  logic        rx_irq_q, rx_irq_d;
  logic        cap, room, drop;
  logic [AW:0] count_nxt;
  rx_entry_t   wr_entry, rd_entry;

  // rx_done stays high through the acknowledge cycle; masking it there yields one capture per character.
  assign cap  = rx_lsr[LSR_DONE] & ~clear_flags_q;
  assign drop = cap & ~room;

  assign wr_entry = '{ferr: rx_lsr[LSR_FERR], perr: rx_lsr[LSR_PERR], data: rx_data};

  sync_fifo #(
    .W     (RXF_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (cap),
    .pop_i       (rd_en),
    .wdata_i     (wr_entry),
    .rdata_o     (rd_entry),
    .count_o     (count),
    .count_nxt_o (count_nxt),
    .full_o      (fifo_full),
    .empty_o     (empty),
    .room_o      (room)
  );

  always_comb begin
    clear_flags_d = cap;
    overrun_d     = overrun_q;
    // A drop or a receiver-reported overrun wins over a host clear in the same cycle.
    if (drop || (cap && rx_lsr[LSR_OVR])) overrun_d = 1'b1;
    else if (overrun_clr)                 overrun_d = 1'b0;
    rx_irq_d = (count_nxt >= (AW+1)'(THRESH));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      clear_flags_q <= 1'b0;
      overrun_q     <= 1'b0;
      rx_irq_q      <= 1'b0;
    end else begin
      clear_flags_q <= clear_flags_d;
      overrun_q     <= overrun_d;
      rx_irq_q      <= rx_irq_d;
    end
  end

  assign clear_flags = clear_flags_q;
  assign overrun     = overrun_q;
  assign rx_irq      = rx_irq_q;
  assign rd_data     = rd_entry.data;
  assign rd_perr     = rd_entry.perr;
  assign rd_ferr     = rd_entry.ferr;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus random traffic against a queue-based reference.
module tb_uart_rx_fifo;

  localparam int DEPTH  = 16;
  localparam int AW     = 4;
  localparam int THRESH = 8;

  logic          clock, reset;
  logic [7:0]    rx_data, rx_lsr;
  logic          clear_flags, fifo_full, rd_en, rd_perr, rd_ferr, empty;
  logic [7:0]    rd_data;
  logic [AW:0]   count;
  logic          overrun, overrun_clr, rx_irq;

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW), .THRESH(THRESH)) dut (
    .clock       (clock),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_lsr      (rx_lsr),
    .clear_flags (clear_flags),
    .fifo_full   (fifo_full),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_perr     (rd_perr),
    .rd_ferr     (rd_ferr),
    .empty       (empty),
    .count       (count),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .rx_irq      (rx_irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference state: the buffered characters as {ferr, perr, data}, plus the three flags.
  logic [9:0] q[$];
  logic       m_cf, m_ovr, m_irq;
  int         total, bad, cf_pulses;
  logic [7:0] last_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("count", 32'(count), 32'(q.size()));
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("fifo_full", 32'(fifo_full), 32'(q.size() == DEPTH));
    check("clear_flags", 32'(clear_flags), 32'(m_cf));
    check("overrun", 32'(overrun), 32'(m_ovr));
    check("rx_irq", 32'(rx_irq), 32'(m_irq));
    if (q.size() != 0) begin
      check("rd_data", 32'(rd_data), 32'(q[0][7:0]));
      check("rd_perr", 32'(rd_perr), 32'(q[0][8]));
      check("rd_ferr", 32'(rd_ferr), 32'(q[0][9]));
    end
  endtask

  // One clock of stimulus; the reference applies the same cycle's rules afterwards.
  task automatic step(input logic [7:0] lsr, input logic [7:0] d, input logic rd, input logic oclr);
    logic cap, pop, room;
    rx_lsr = lsr; rx_data = d; rd_en = rd; overrun_clr = oclr;
    cap  = lsr[0] && !m_cf;
    pop  = rd && (q.size() != 0);
    room = (q.size() < DEPTH) || pop;
    if (pop) last_rd = rd_data;
    @(posedge clock); #1;
    if (pop) void'(q.pop_front());
    if (cap && room) q.push_back({lsr[3], lsr[2], d});
    if (cap && (!room || lsr[1])) m_ovr = 1'b1;
    else if (oclr)                m_ovr = 1'b0;
    m_cf  = cap;
    m_irq = (q.size() >= THRESH);
    if (clear_flags) cf_pulses++;
    check_all();
  endtask

  // Receiver behaviour: flags held through the acknowledge cycle, then released.
  task automatic send_char(input logic [7:0] d, input logic [7:0] lsr, input logic rd_first);
    step(lsr, d, rd_first, 1'b0);
    step(lsr, d, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1; rx_lsr = '0; rx_data = '0; rd_en = 1'b0; overrun_clr = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    q.delete(); m_cf = 1'b0; m_ovr = 1'b0; m_irq = 1'b0;
    check_all();
  endtask

  initial begin
    int p0;
    total = 0; bad = 0; cf_pulses = 0; last_rd = '0;
    reset = 1'b1; rx_lsr = '0; rx_data = '0; rd_en = 1'b0; overrun_clr = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    do_reset();

    // 1: single capture
    p0 = cf_pulses;
    send_char(8'hA5, 8'h01, 1'b0);
    step(8'h00, 8'h00, 1'b0, 1'b0);
    check("t1_pulses", 32'(cf_pulses - p0), 32'd1);
    check("t1_count", 32'(count), 32'd1);
    check("t1_data", 32'(rd_data), 32'hA5);
    step(8'h00, 8'h00, 1'b1, 1'b0);

    // 2: error tagging
    send_char(8'h3C, 8'h0D, 1'b0);
    check("t2_data", 32'(rd_data), 32'h3C);
    check("t2_perr", 32'(rd_perr), 32'd1);
    check("t2_ferr", 32'(rd_ferr), 32'd1);
    check("t2_ovr", 32'(overrun), 32'd0);
    step(8'h00, 8'h00, 1'b1, 1'b0);

    // 3: fill and drop
    p0 = cf_pulses;
    for (int i = 0; i < 16; i++) send_char(8'(i), 8'h01, 1'b0);
    send_char(8'hFF, 8'h01, 1'b0);
    check("t3_pulses", 32'(cf_pulses - p0), 32'd17);
    check("t3_full", 32'(fifo_full), 32'd1);
    check("t3_ovr", 32'(overrun), 32'd1);
    for (int i = 0; i < 16; i++) begin
      step(8'h00, 8'h00, 1'b1, 1'b0);
      check("t3_order", 32'(last_rd), 32'(i));
    end
    check("t3_empty", 32'(empty), 32'd1);
    step(8'h00, 8'h00, 1'b0, 1'b1);

    // 4: full with simultaneous push and pop
    for (int i = 0; i < 16; i++) send_char(8'(8'h80 + i), 8'h01, 1'b0);
    send_char(8'h55, 8'h01, 1'b1);
    check("t4_count", 32'(count), 32'd16);
    check("t4_ovr", 32'(overrun), 32'd0);
    for (int i = 0; i < 16; i++) step(8'h00, 8'h00, 1'b1, 1'b0);
    check("t4_last", 32'(last_rd), 32'h55);

    // 5: threshold and pointer wrap
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) send_char(8'(r * 16 + i), 8'h01, 1'b0);
      check("t5_irq_hi", 32'(rx_irq), 32'd1);
      step(8'h00, 8'h00, 1'b1, 1'b0);
      check("t5_irq_lo", 32'(rx_irq), 32'd0);
      for (int i = 1; i < 8; i++) step(8'h00, 8'h00, 1'b1, 1'b0);
      check("t5_last", 32'(last_rd), 32'(r * 16 + 7));
    end

    // 6: reset mid-stream with an acknowledge pending
    for (int i = 0; i < 5; i++) send_char(8'(8'h40 + i), 8'h01, 1'b0);
    step(8'h01, 8'h77, 1'b0, 1'b0);
    check("t6_cf_pre", 32'(clear_flags), 32'd1);
    do_reset();
    check("t6_count", 32'(count), 32'd0);
    check("t6_cf", 32'(clear_flags), 32'd0);
    step(8'h00, 8'h00, 1'b1, 1'b0);
    check("t6_idle", 32'(count), 32'd0);

    // random traffic against the reference
    for (int i = 0; i < 600; i++)
      step(8'($urandom_range(0, 15)), 8'($urandom), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 9) == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
